// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared types and constants for the hazard controller
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_PEND = 2'd1,
        MD_WAIT = 2'd2
    } state_e;

    localparam int          CTRL_W           = 9;
    localparam logic [31:0] RESET_TARGET_DEF = 32'd0;

    typedef struct packed {
        logic pc_stall;
        logic pc_redirect;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
        logic mem_wb_stall;
    } ctrl_t;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// rtl/pipeline_hazard_controller_sat_counter.sv - saturating incrementer with enable and sync active-low clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clear_n_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/redirect sequencer for the 5-stage pipeline
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_TARGET = RESET_TARGET_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IMEM_BUSY,
    input  logic             DMEM_BUSY,
    input  logic             LOAD_USE_HAZARD,
    input  logic             BRANCH_TAKEN,
    input  logic [31:0]      BRANCH_TARGET,
    input  logic             MULDIV_START,
    input  logic             MULDIV_DONE,
    output logic             PC_STALL,
    output logic             PC_REDIRECT,
    output logic [31:0]      PC_TARGET,
    output logic             IF_ID_STALL,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_STALL,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_STALL,
    output logic             EX_MEM_FLUSH,
    output logic             MEM_WB_STALL,
    output logic [CNT_W-1:0] STALL_COUNT
);

    state_e      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    ctrl_t       ctrl;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= RUN;
            pend_target_q <= RESET_TARGET;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    // A DMEM freeze holds EX, so any branch or mul/div event is re-presented later.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        if (!DMEM_BUSY) begin
            case (state_q)
                MD_WAIT: if (MULDIV_DONE) state_d = RUN;
                BR_PEND: if (!IMEM_BUSY) state_d = RUN;
                default: begin
                    if (BRANCH_TAKEN) begin
                        if (IMEM_BUSY) begin
                            state_d       = BR_PEND;
                            pend_target_d = BRANCH_TARGET;
                        end
                    end else if (MULDIV_START && !MULDIV_DONE) begin
                        state_d = MD_WAIT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ctrl      = '0;
        PC_TARGET = pend_target_q;
        if (!RESET) begin
            ctrl = '0;
        end else if (DMEM_BUSY) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_stall = 1'b1;
        end else begin
            case (state_q)
                MD_WAIT: begin
                    if (!MULDIV_DONE) begin
                        ctrl.pc_stall     = 1'b1;
                        ctrl.if_id_stall  = 1'b1;
                        ctrl.id_ex_stall  = 1'b1;
                        ctrl.ex_mem_flush = 1'b1;
                    end
                end
                BR_PEND: begin
                    ctrl.if_id_flush = 1'b1;
                    if (IMEM_BUSY) begin
                        ctrl.pc_stall = 1'b1;
                    end else begin
                        ctrl.pc_redirect = 1'b1;
                    end
                end
                default: begin
                    if (BRANCH_TAKEN) begin
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                        if (IMEM_BUSY) begin
                            ctrl.pc_stall = 1'b1;
                        end else begin
                            ctrl.pc_redirect = 1'b1;
                            PC_TARGET        = BRANCH_TARGET;
                        end
                    end else if (MULDIV_START && !MULDIV_DONE) begin
                        ctrl.pc_stall     = 1'b1;
                        ctrl.if_id_stall  = 1'b1;
                        ctrl.id_ex_stall  = 1'b1;
                        ctrl.ex_mem_flush = 1'b1;
                    end else if (LOAD_USE_HAZARD) begin
                        ctrl.pc_stall    = 1'b1;
                        ctrl.if_id_stall = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (IMEM_BUSY) begin
                        ctrl.pc_stall    = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign PC_STALL     = ctrl.pc_stall;
    assign PC_REDIRECT  = ctrl.pc_redirect;
    assign IF_ID_STALL  = ctrl.if_id_stall;
    assign IF_ID_FLUSH  = ctrl.if_id_flush;
    assign ID_EX_STALL  = ctrl.id_ex_stall;
    assign ID_EX_FLUSH  = ctrl.id_ex_flush;
    assign EX_MEM_STALL = ctrl.ex_mem_stall;
    assign EX_MEM_FLUSH = ctrl.ex_mem_flush;
    assign MEM_WB_STALL = ctrl.mem_wb_stall;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i     (CLK),
        .clear_n_i (RESET),
        .en_i      (ctrl.pc_stall),
        .count_o   (STALL_COUNT)
    );

endmodule
